// File: rtl/tone_scheduler.sv
// tone_scheduler: sequences the PWM tone datapath from a small programmable song memory.
//
// Each song entry holds a pitch code and a length. The scheduler steps through the
// entries, giving each note 4B-1 ticks of sound followed by one tick of space
// (B = len + 1 beats). During a space it can grant a one-shot sound effect, which
// plays for 3 ticks plus 1 tick of space before the melody resumes at the next entry.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   cfg_we/addr/data  song memory write port; data = {code[2:0], len[2:0], reserved[1:0]}
//   start, stop       playback control pulses (stop wins over start)
//   loop              level; restart at entry 0 when the end marker is fetched
//   sfx_req/sfx_code  sound-effect request and its pitch code
//   sfx_ack           one-cycle grant pulse
//   sample_stb        one-cycle strobe every SAMPLE_DIV clocks while busy
//   gate, inc         datapath gate and phase increment for the sounding pitch
//   pos               index of the current song entry
//   busy, done        playback active; one-cycle pulse on a non-loop end
module tone_scheduler #(
    parameter int unsigned SAMPLE_DIV   = 128,
    parameter int unsigned TICK_SAMPLES = 5468,
    parameter int unsigned DEPTH        = 32,
    parameter int unsigned INC_BITS     = 7,
    localparam int unsigned AW          = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [7:0]          cfg_data,
    input  logic                start,
    input  logic                stop,
    input  logic                loop,
    input  logic                sfx_req,
    input  logic [2:0]          sfx_code,
    output logic                sfx_ack,
    output logic                sample_stb,
    output logic                gate,
    output logic [INC_BITS-1:0] inc,
    output logic [AW-1:0]       pos,
    output logic                busy,
    output logic                done
);

    localparam int unsigned SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned TW = (TICK_SAMPLES > 1) ? $clog2(TICK_SAMPLES) : 1;

    localparam logic [2:0] CodeRest = 3'd6;
    localparam logic [2:0] CodeEnd  = 3'd7;

    typedef enum logic [2:0] {
        StIdle,
        StSound,
        StSpace,
        StSfxSound,
        StSfxSpace
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] samp_q, samp_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [4:0]    cnt_q, cnt_d;     // tick boundaries seen in the current state
    logic [AW-1:0] pos_q, pos_d;
    logic [2:0]    code_q, code_d;   // latched pitch of the playing note or effect
    logic [2:0]    len_q, len_d;
    logic          wrap_q, wrap_d;   // in the extra space after a looped end marker
    logic          done_q, done_d;
    logic          ack_q, ack_d;

    logic [5:0]    mem [DEPTH];      // {code, len}
    logic [AW-1:0] fetch_addr;
    logic [2:0]    fetch_code;
    logic [2:0]    fetch_len;
    logic          sample_end;
    logic          tick_end;
    logic          advance;
    logic          sounding;
    logic          unused_cfg;

    assign unused_cfg = ^cfg_data[1:0];

    function automatic logic [INC_BITS-1:0] pitch_inc(input logic [2:0] code);
        case (code)
            3'd0:    return INC_BITS'(67);
            3'd1:    return INC_BITS'(60);
            3'd2:    return INC_BITS'(50);
            3'd3:    return INC_BITS'(48);
            3'd4:    return INC_BITS'(45);
            3'd5:    return INC_BITS'(40);
            default: return '0;
        endcase
    endfunction

    // Song memory: written at any time, never reset.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            mem[cfg_addr] <= cfg_data[7:2];
        end
    end

    // From IDLE and from the looped-end space the next entry is always entry 0.
    always_comb begin
        if (state_q == StIdle || wrap_q) begin
            fetch_addr = '0;
        end else begin
            fetch_addr = pos_q + 1'b1;
        end
        fetch_code = mem[fetch_addr][5:3];
        fetch_len  = mem[fetch_addr][2:0];
    end

    assign sample_end = (state_q != StIdle) && (samp_q == SW'(SAMPLE_DIV - 1));
    assign tick_end   = sample_end && (tick_q == TW'(TICK_SAMPLES - 1));

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        code_d  = code_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        wrap_d  = wrap_q;
        done_d  = 1'b0;
        ack_d   = 1'b0;
        advance = 1'b0;

        case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    pos_d  = '0;
                    wrap_d = 1'b0;
                    cnt_d  = '0;
                    if (fetch_code == CodeEnd) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StSound;
                        code_d  = fetch_code;
                        len_d   = fetch_len;
                    end
                end
            end
            StSound: begin
                // Last sounding tick is number 4*len+2 (4B-1 ticks in total).
                if (tick_end) begin
                    if (cnt_q == {len_q, 2'b10}) begin
                        state_d = StSpace;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StSpace: begin
                // The looped-end space belongs to no note, so it never grants an effect.
                if (tick_end) begin
                    if (sfx_req && !wrap_q) begin
                        ack_d   = 1'b1;
                        state_d = StSfxSound;
                        code_d  = sfx_code;
                        cnt_d   = '0;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            StSfxSound: begin
                if (tick_end) begin
                    if (cnt_q == 5'd2) begin
                        state_d = StSfxSpace;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StSfxSpace: begin
                if (tick_end) begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (advance) begin
            pos_d  = fetch_addr;
            wrap_d = 1'b0;
            cnt_d  = '0;
            if (fetch_code == CodeEnd) begin
                if (loop) begin
                    pos_d   = '0;
                    wrap_d  = 1'b1;
                    state_d = StSpace;
                end else begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end else begin
                state_d = StSound;
                code_d  = fetch_code;
                len_d   = fetch_len;
            end
        end

        if (stop && state_q != StIdle) begin
            state_d = StIdle;
            done_d  = 1'b0;
            ack_d   = 1'b0;
            wrap_d  = 1'b0;
            cnt_d   = '0;
        end
    end

    // Sample and tick counters run only while playing; zeroed on start and on return to IDLE.
    always_comb begin
        samp_d = samp_q;
        tick_d = tick_q;
        if (state_q == StIdle || state_d == StIdle) begin
            samp_d = '0;
            tick_d = '0;
        end else if (sample_end) begin
            samp_d = '0;
            tick_d = tick_end ? '0 : tick_q + 1'b1;
        end else begin
            samp_d = samp_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            samp_q  <= '0;
            tick_q  <= '0;
            cnt_q   <= '0;
            pos_q   <= '0;
            code_q  <= '0;
            len_q   <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            samp_q  <= samp_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            code_q  <= code_d;
            len_q   <= len_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
        end
    end

    // Rests (code 6) and silent effect codes (6, 7) keep the gate low and the increment zero.
    assign sounding = (state_q == StSound || state_q == StSfxSound) && (code_q < CodeRest);

    assign gate       = sounding;
    assign inc        = sounding ? pitch_inc(code_q) : '0;
    assign pos        = pos_q;
    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign sfx_ack    = ack_q;
    assign sample_stb = sample_end;

endmodule
